// File: rtl/reset_seq_pkg.sv
// reset_seq_pkg: shared types and helpers for the reset sequencer.
//   state_e   - FSM state encoding (ASSERTING is always present so the
//               encoding does not change with the ordered-assert build)
//   cnt_width - width of the hold/gap counter
package reset_seq_pkg;

  typedef enum logic [1:0] {
    ST_ASSERT    = 2'd0,
    ST_RELEASE   = 2'd1,
    ST_RUN       = 2'd2,
    ST_ASSERTING = 2'd3
  } state_e;

  // Bits needed to count up to the larger of the hold and gap lengths.
  function automatic int unsigned cnt_width(input int unsigned hold,
                                            input int unsigned gap);
    int unsigned m;
    m = (hold > gap) ? hold : gap;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/reset_sync_chain.sv
// reset_sync_chain: asynchronous-assert / synchronous-deassert reset
// synchroniser.
//   clk           in  domain clock
//   async_reset_n in  asynchronous active-low reset
//   sync_reset_n  out reset deasserted STAGES clk edges after async release
module reset_sync_chain #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic async_reset_n,
  output logic sync_reset_n
);

  if (STAGES < 2) begin : g_bad_stages
    $error("reset_sync_chain: STAGES must be >= 2");
  end

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge async_reset_n) begin
    if (!async_reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], 1'b1};
    end
  end

  assign sync_reset_n = sync_q[STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// reset_sequencer: synchronises board reset into the clk domain, stretches
// it for HOLD_CYCLES, then releases NUM_OUTPUTS resets one by one (bit 0
// first) GAP_CYCLES apart. A rising edge on sw_reset_req re-asserts all
// outputs and is acknowledged with a one-cycle sw_reset_ack pulse.
//   clk           in  domain clock
//   async_reset_n in  asynchronous active-low reset
//   sw_reset_req  in  software reset request (level, acted on rising edge)
//   sw_reset_ack  out one-cycle acknowledge of an accepted request
//   reset_n_out   out sequenced active-low resets
//   all_released  out every reset_n_out bit is high
//   busy          out FSM is not in RUN
// Build option: RESET_SEQ_ORDERED_ASSERT_EN - a software request drops the
// outputs in reverse order (highest bit first, GAP_CYCLES apart) instead of
// all at once.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned HOLD_CYCLES = 16,
  parameter int unsigned NUM_OUTPUTS = 4,
  parameter int unsigned GAP_CYCLES  = 8
) (
  input  logic                   clk,
  input  logic                   async_reset_n,
  input  logic                   sw_reset_req,
  output logic                   sw_reset_ack,
  output logic [NUM_OUTPUTS-1:0] reset_n_out,
  output logic                   all_released,
  output logic                   busy
);

  if (HOLD_CYCLES < 1 || NUM_OUTPUTS < 1 || GAP_CYCLES < 1) begin : g_bad_params
    $error("reset_sequencer: HOLD_CYCLES, NUM_OUTPUTS and GAP_CYCLES must be >= 1");
  end

  localparam int unsigned    CNT_W     = cnt_width(HOLD_CYCLES, GAP_CYCLES);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

  logic                   rst_n;
  state_e                 state;
  logic [CNT_W-1:0]       cnt;
  logic                   req_q;
  logic                   req_rise;
  logic [NUM_OUTPUTS-1:0] rel_next;

  reset_sync_chain #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk          (clk),
    .async_reset_n(async_reset_n),
    .sync_reset_n (rst_n)
  );

  assign req_rise = sw_reset_req & ~req_q;

  // Outputs always form a run of ones from bit 0, so releasing the next
  // bit is a shift-in of a one at the bottom.
  assign rel_next = (reset_n_out << 1) | NUM_OUTPUTS'(1);

`ifdef RESET_SEQ_ORDERED_ASSERT_EN
  logic [NUM_OUTPUTS-1:0] drop_next;
  // Dropping the highest still-high bit of a low-aligned run of ones.
  assign drop_next = reset_n_out >> 1;
`endif

  always_ff @(posedge clk or negedge async_reset_n) begin
    if (!async_reset_n) begin
      state        <= ST_ASSERT;
      cnt          <= '0;
      req_q        <= 1'b0;
      sw_reset_ack <= 1'b0;
      reset_n_out  <= '0;
      all_released <= 1'b0;
      busy         <= 1'b1;
    end else begin
      req_q        <= sw_reset_req;
      sw_reset_ack <= 1'b0;
      if (req_rise) begin
        sw_reset_ack <= 1'b1;
        cnt          <= '0;
        all_released <= 1'b0;
        busy         <= 1'b1;
`ifdef RESET_SEQ_ORDERED_ASSERT_EN
        reset_n_out  <= drop_next;
        state        <= (drop_next == '0) ? ST_ASSERT : ST_ASSERTING;
`else
        reset_n_out  <= '0;
        state        <= ST_ASSERT;
`endif
      end else begin
        case (state)
          ST_ASSERT: begin
            if (rst_n) begin
              if (cnt == HOLD_LAST) begin
                cnt         <= '0;
                reset_n_out <= rel_next;
                if (rel_next == '1) begin
                  state        <= ST_RUN;
                  all_released <= 1'b1;
                  busy         <= 1'b0;
                end else begin
                  state <= ST_RELEASE;
                end
              end else begin
                cnt <= cnt + 1'b1;
              end
            end
          end
          ST_RELEASE: begin
            if (cnt == GAP_LAST) begin
              cnt         <= '0;
              reset_n_out <= rel_next;
              if (rel_next == '1) begin
                state        <= ST_RUN;
                all_released <= 1'b1;
                busy         <= 1'b0;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          ST_RUN: begin
            reset_n_out <= '1;
          end
          ST_ASSERTING: begin
`ifdef RESET_SEQ_ORDERED_ASSERT_EN
            if (cnt == GAP_LAST) begin
              cnt         <= '0;
              reset_n_out <= drop_next;
              if (drop_next == '0) begin
                state <= ST_ASSERT;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
`else
            state <= ST_ASSERT;
`endif
          end
          default: begin
            state <= ST_ASSERT;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
module tb_reset_sequencer;
  import reset_seq_pkg::*;

  logic       clk = 1'b0;
  logic       async_reset_n;
  logic       sw_reset_req;
  logic       sw_reset_ack;
  logic [3:0] reset_n_out;
  logic       all_released;
  logic       busy;

  int n_total = 0;
  int n_pass  = 0;
  int cyc     = 0;

  typedef struct {
    logic [3:0] pat;
    int         cyc;
  } ev_t;

  ev_t        exp_q[$];
  int         ack_q[$];
  logic [3:0] prev_out = 4'h0;
  logic       mon_en   = 1'b0;

  reset_sequencer #(
    .SYNC_STAGES(2),
    .HOLD_CYCLES(16),
    .NUM_OUTPUTS(4),
    .GAP_CYCLES (8)
  ) dut (
    .clk          (clk),
    .async_reset_n(async_reset_n),
    .sw_reset_req (sw_reset_req),
    .sw_reset_ack (sw_reset_ack),
    .reset_n_out  (reset_n_out),
    .all_released (all_released),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
  endtask

  task automatic at_cycle(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic push_ev(input logic [3:0] pat, input int c);
    ev_t e;
    e.pat = pat;
    e.cyc = c;
    exp_q.push_back(e);
  endtask

  // Scoreboard: every change of reset_n_out and every ack pulse must match
  // the next expected event, both in value and in cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      if (reset_n_out !== prev_out) begin
        check("out_event_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          ev_t e;
          e = exp_q.pop_front();
          check("out_pattern", 32'(reset_n_out), 32'(e.pat));
          check("out_cycle", cyc, e.cyc);
        end
        prev_out = reset_n_out;
      end
      if (sw_reset_ack === 1'b1) begin
        check("ack_expected", 32'(ack_q.size() > 0), 32'd1);
        if (ack_q.size() > 0) check("ack_cycle", cyc, ack_q.pop_front());
      end
    end
  end

  initial begin
    #5000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    int c;
    int d;
    int s;
    int fin;

    async_reset_n = 1'b1;
    sw_reset_req  = 1'b0;
    #1 async_reset_n = 1'b0;

    // Power-on reset state
    repeat (5) @(negedge clk);
    #2;
    check("rst_out", 32'(reset_n_out), 32'h0);
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_all", 32'(all_released), 32'd0);
    check("rst_ack", 32'(sw_reset_ack), 32'd0);
    mon_en = 1'b1;

    // Release, then async reset in the middle of the sequence
    r = cyc;
    async_reset_n = 1'b1;
    push_ev(4'h1, r + 18);
    push_ev(4'h3, r + 26);
    at_cycle(r + 30);
    #2;
    async_reset_n = 1'b0;
    #1;
    check("mid_async_out", 32'(reset_n_out), 32'h0);
    check("mid_async_busy", 32'(busy), 32'd1);
    check("mid_async_all", 32'(all_released), 32'd0);
    push_ev(4'h0, r + 31);

    // Full restart after release
    repeat (3) @(negedge clk);
    #2;
    r = cyc;
    async_reset_n = 1'b1;
    push_ev(4'h1, r + 18);
    push_ev(4'h3, r + 26);
    push_ev(4'h7, r + 34);
    push_ev(4'hF, r + 42);
    at_cycle(r + 42);
    #1;
    check("por_all_released", 32'(all_released), 32'd1);
    check("por_busy", 32'(busy), 32'd0);

    // Software request in RUN, held high for 3 cycles
    repeat (4) @(negedge clk);
    #2;
    c = cyc;
    sw_reset_req = 1'b1;
    ack_q.push_back(c + 1);
`ifdef RESET_SEQ_ORDERED_ASSERT_EN
    push_ev(4'h7, c + 1);
    push_ev(4'h3, c + 9);
`else
    push_ev(4'h0, c + 1);
`endif
    @(negedge clk);
    #1;
    check("sw_ack_pulse", 32'(sw_reset_ack), 32'd1);
    check("sw_all_fall", 32'(all_released), 32'd0);
    check("sw_busy", 32'(busy), 32'd1);
    at_cycle(c + 3);
    #2;
    sw_reset_req = 1'b0;

    // Second request 10 cycles into the hold restarts it
    at_cycle(c + 11);
    #2;
    d = cyc;
    sw_reset_req = 1'b1;
    ack_q.push_back(d + 1);
`ifdef RESET_SEQ_ORDERED_ASSERT_EN
    push_ev(4'h1, d + 1);
    push_ev(4'h0, d + 9);
    fin = d + 9 + 16;
`else
    fin = d + 1 + 16;
`endif
    push_ev(4'h1, fin);
    push_ev(4'h3, fin + 8);
    push_ev(4'h7, fin + 16);
    push_ev(4'hF, fin + 24);
    at_cycle(d + 3);
    #2;
    sw_reset_req = 1'b0;
    at_cycle(fin + 24);
    #1;
    check("sw_all_released", 32'(all_released), 32'd1);
    check("sw_busy_run", 32'(busy), 32'd0);

    // Request rising on the same cycle async reset falls
    repeat (3) @(negedge clk);
    #2;
    s = cyc;
    sw_reset_req  = 1'b1;
    async_reset_n = 1'b0;
    push_ev(4'h0, s + 1);
    repeat (3) @(negedge clk);
    #1;
    check("sim_ack", 32'(sw_reset_ack), 32'd0);
    check("sim_state", 32'(dut.state), 32'(ST_ASSERT));
    check("sim_cnt", 32'(dut.cnt), 32'd0);
    check("sim_out", 32'(reset_n_out), 32'h0);
    check("sim_busy", 32'(busy), 32'd1);
    sw_reset_req = 1'b0;
    repeat (2) @(negedge clk);
    #1;

    check("events_left", 32'(exp_q.size()), 32'd0);
    check("acks_left", 32'(ack_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
